rv_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory bus. It serves word fetches on a simple select/ready request port. On a miss it refills one full line with an incrementing burst on the downstream port. A fence.i pulse from decode invalidates the whole cache.

---
 rtl/rv_icache_if.sv | 32 +++
 rtl/rv_icache.sv | 137 +++++++++++++
 tb/tb_rv_icache.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rv_icache_if.sv
// rv_icache_if: bus bundle for the instruction cache.
//   Fetch side : in_paddr/in_psel -> in_pready/in_prdata, plus in_fence_flag.
//   Memory side: out_paddr/out_psel/out_arlen/out_arsize -> out_rvalid/out_rlast/out_rdata.
// Modport slave is the cache itself; modport master is the surrounding fetch
// stage plus memory bus (or a testbench standing in for both).
interface rv_icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] in_paddr;
    logic                  in_psel;
    logic                  in_pready;
    logic [DATA_WIDTH-1:0] in_prdata;
    logic                  in_fence_flag;
    logic [ADDR_WIDTH-1:0] out_paddr;
    logic                  out_psel;
    logic [7:0]            out_arlen;
    logic [2:0]            out_arsize;
    logic                  out_rvalid;
    logic                  out_rlast;
    logic [DATA_WIDTH-1:0] out_rdata;

    modport slave (
        input  in_paddr, in_psel, in_fence_flag, out_rvalid, out_rlast, out_rdata,
        output in_pready, in_prdata, out_paddr, out_psel, out_arlen, out_arsize
    );

    modport master (
        output in_paddr, in_psel, in_fence_flag, out_rvalid, out_rlast, out_rdata,
        input  in_pready, in_prdata, out_paddr, out_psel, out_arlen, out_arsize
    );
endinterface

// File: rtl/rv_icache.sv
// rv_icache: direct-mapped, read-only instruction cache.
//   clock : single rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : rv_icache_if.slave (fetch request port, refill burst port, fence.i)
// A miss refills the whole line with one incrementing burst; fence.i clears
// every valid bit (deferred to the end of a refill if one is in flight).
//
// state | meaning
// IDLE  | waiting for a fetch; hit lookup happens here
// HIT   | returning the word latched on a hit
// FILL  | refill burst in progress on the memory side
// RESP  | returning the requested word of the refilled line
module rv_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input logic        clock,
    input logic        rstn,
    rv_icache_if.slave bus
);
    localparam int WSEL_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS  = WSEL_BITS + 2;
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;

    typedef enum logic [1:0] {IDLE, HIT, FILL, RESP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES][LINE_WORDS];
    logic [WSEL_BITS-1:0]  beat;
    logic                  fence_pending;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  psel_q;
    logic [ADDR_WIDTH-1:0] paddr_q;

    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [WSEL_BITS-1:0]  req_wsel;
    logic [IDX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [WSEL_BITS-1:0]  fill_wsel;
    logic                  hit;
    logic                  beat_fire;
    logic                  fill_done;

    always_comb begin
        req_idx   = bus.in_paddr[OFF_BITS +: IDX_BITS];
        req_tag   = bus.in_paddr[ADDR_WIDTH-1 -: TAG_BITS];
        req_wsel  = bus.in_paddr[2 +: WSEL_BITS];
        fill_idx  = addr_q[OFF_BITS +: IDX_BITS];
        fill_tag  = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
        fill_wsel = addr_q[2 +: WSEL_BITS];
        // A fence on the same cycle as the lookup forces a miss.
        hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !bus.in_fence_flag;
        beat_fire = (state == FILL) && bus.out_rvalid;
        fill_done = beat_fire && bus.out_rlast;
    end

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clock) begin
        if (beat_fire) data_mem[fill_idx][beat] <= bus.out_rdata;
        if (fill_done) tag_mem[fill_idx] <= fill_tag;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            addr_q        <= '0;
            valid         <= '0;
            beat          <= '0;
            fence_pending <= 1'b0;
            pready        <= 1'b0;
            prdata        <= '0;
            psel_q        <= 1'b0;
            paddr_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_fence_flag) valid <= '0;
                    if (bus.in_psel) begin
                        addr_q <= bus.in_paddr;
                        if (hit) begin
                            prdata <= data_mem[req_idx][req_wsel];
                            pready <= 1'b1;
                            state  <= HIT;
                        end else begin
                            psel_q  <= 1'b1;
                            paddr_q <= {bus.in_paddr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                            state   <= FILL;
                        end
                    end
                end
                HIT: begin
                    pready <= 1'b0;
                    if (bus.in_fence_flag) valid <= '0;
                    state <= IDLE;
                end
                FILL: begin
                    if (bus.in_fence_flag) fence_pending <= 1'b1;
                    if (beat_fire) beat <= beat + 1'b1;
                    if (fill_done) begin
                        if (fence_pending || bus.in_fence_flag) valid <= '0;
                        else valid[fill_idx] <= 1'b1;
                        fence_pending <= 1'b0;
                        psel_q        <= 1'b0;
                        paddr_q       <= '0;
                        pready        <= 1'b1;
                        // The requested word may be arriving on this very beat.
                        prdata <= (beat == fill_wsel) ? bus.out_rdata
                                                      : data_mem[fill_idx][fill_wsel];
                        state  <= RESP;
                    end
                end
                RESP: begin
                    pready <= 1'b0;
                    beat   <= '0;
                    if (bus.in_fence_flag) valid <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_pready  = pready;
    assign bus.in_prdata  = prdata;
    assign bus.out_psel   = psel_q;
    assign bus.out_paddr  = paddr_q;
    assign bus.out_arlen  = 8'(LINE_WORDS - 1);
    assign bus.out_arsize = 3'b010;
endmodule

// File: tb/tb_rv_icache.sv
// tb_rv_icache: directed bench for rv_icache. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-derived.
module tb_rv_icache;
    logic clock;
    logic rstn;
    int   total;
    int   bad;

    rv_icache_if bus ();

    rv_icache dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
        bus.in_paddr = addr;
        bus.in_psel  = 1'b1;
        @(negedge clock);
        chk("hit_pready", 32'(bus.in_pready), 32'd1);
        chk("hit_data", bus.in_prdata, exp);
        chk("hit_no_refill", 32'(bus.out_psel), 32'd0);
        bus.in_psel = 1'b0;
        @(negedge clock);
        chk("hit_pulse", 32'(bus.in_pready), 32'd0);
    endtask

    // Word i of the refill is base + i*step; the requested word is selected by addr[3:2].
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base,
                           input logic [31:0] step, input int gap,
                           input int fence_beat, input bit fence_req);
        logic [31:0] line;
        logic [31:0] exp;
        logic [1:0]  ws;
        line = addr & 32'hFFFF_FFF0;
        ws   = addr[3:2];
        exp  = base + step * 32'(ws);
        bus.in_paddr      = addr;
        bus.in_psel       = 1'b1;
        bus.in_fence_flag = fence_req;
        @(negedge clock);
        bus.in_fence_flag = 1'b0;
        chk("miss_psel", 32'(bus.out_psel), 32'd1);
        chk("miss_paddr", bus.out_paddr, line);
        chk("miss_arlen", 32'(bus.out_arlen), 32'd3);
        chk("miss_arsize", 32'(bus.out_arsize), 32'd2);
        chk("miss_pready", 32'(bus.in_pready), 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.out_rvalid = 1'b0;
                @(negedge clock);
                chk("gap_psel", 32'(bus.out_psel), 32'd1);
                chk("gap_paddr", bus.out_paddr, line);
                chk("gap_pready", 32'(bus.in_pready), 32'd0);
            end
            bus.out_rvalid    = 1'b1;
            bus.out_rdata     = base + step * 32'(b);
            bus.out_rlast     = (b == 3);
            bus.in_fence_flag = (b == fence_beat);
            @(negedge clock);
            bus.out_rvalid    = 1'b0;
            bus.out_rlast     = 1'b0;
            bus.in_fence_flag = 1'b0;
            if (b < 3) begin
                chk("beat_psel", 32'(bus.out_psel), 32'd1);
                chk("beat_paddr", bus.out_paddr, line);
                chk("beat_pready", 32'(bus.in_pready), 32'd0);
            end else begin
                chk("resp_pready", 32'(bus.in_pready), 32'd1);
                chk("resp_data", bus.in_prdata, exp);
                chk("resp_psel", 32'(bus.out_psel), 32'd0);
                chk("resp_paddr", bus.out_paddr, 32'd0);
                bus.in_psel = 1'b0;
            end
        end
        @(negedge clock);
        chk("resp_pulse", 32'(bus.in_pready), 32'd0);
    endtask

    task automatic fence_pulse();
        bus.in_fence_flag = 1'b1;
        @(negedge clock);
        bus.in_fence_flag = 1'b0;
        chk("fence_idle_pready", 32'(bus.in_pready), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.in_paddr      = '0;
        bus.in_psel       = 1'b0;
        bus.in_fence_flag = 1'b0;
        bus.out_rvalid    = 1'b0;
        bus.out_rlast     = 1'b0;
        bus.out_rdata     = '0;
        repeat (2) @(negedge clock);
        chk("rst_pready", 32'(bus.in_pready), 32'd0);
        chk("rst_prdata", bus.in_prdata, 32'd0);
        chk("rst_psel", 32'(bus.out_psel), 32'd0);
        chk("rst_paddr", bus.out_paddr, 32'd0);
        chk("rst_arlen", 32'(bus.out_arlen), 32'd3);
        chk("rst_arsize", 32'(bus.out_arsize), 32'd2);
        rstn = 1'b1;
        @(negedge clock);

        // Cold miss, then hits in the same line.
        do_miss(32'h8000_0004, 32'h11, 32'h11, 0, -1, 1'b0);
        do_hit(32'h8000_000C, 32'h44);
        do_hit(32'h8000_0000, 32'h11);

        // Conflict eviction on index 0, then the old line refetches.
        do_miss(32'h8000_0100, 32'hA0, 32'h1, 0, -1, 1'b0);
        do_miss(32'h8000_0000, 32'h51, 32'h1, 0, -1, 1'b0);
        do_hit(32'h8000_0008, 32'h53);

        // Fence in IDLE invalidates everything.
        fence_pulse();
        do_miss(32'h8000_0100, 32'hB0, 32'h1, 0, -1, 1'b0);
        do_hit(32'h8000_0104, 32'hB1);
        fence_pulse();
        do_miss(32'h8000_0104, 32'hD0, 32'h1, 0, -1, 1'b0);

        // Fence during fill: data still returned, line left invalid.
        do_miss(32'h8000_0210, 32'hE0, 32'h1, 0, 1, 1'b0);
        do_miss(32'h8000_0210, 32'hF0, 32'h1, 0, -1, 1'b0);
        do_hit(32'h8000_0214, 32'hF1);

        // Fence together with a request to a resident line forces a miss.
        do_miss(32'h8000_0214, 32'h300, 32'h1, 0, -1, 1'b1);

        // Stalled burst with 3-cycle gaps between beats.
        do_miss(32'h8000_0308, 32'h100, 32'h1, 3, -1, 1'b0);
        do_hit(32'h8000_030C, 32'h103);

        // Reset in the middle of a burst.
        bus.in_paddr = 32'h8000_0404;
        bus.in_psel  = 1'b1;
        @(negedge clock);
        chk("rstfill_psel", 32'(bus.out_psel), 32'd1);
        for (int b = 0; b < 2; b++) begin
            bus.out_rvalid = 1'b1;
            bus.out_rdata  = 32'h900 + 32'(b);
            @(negedge clock);
        end
        bus.out_rvalid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rstfill_psel_drop", 32'(bus.out_psel), 32'd0);
        chk("rstfill_paddr", bus.out_paddr, 32'd0);
        bus.in_psel = 1'b0;
        @(negedge clock);
        rstn = 1'b1;
        @(negedge clock);
        do_miss(32'h8000_0404, 32'h200, 32'h1, 0, -1, 1'b0);
        do_miss(32'h8000_030C, 32'h400, 32'h1, 1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
